// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and helpers for the sync FIFO family
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Address width needed to index depth words.
  function automatic int fifo_aw(input int depth);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < depth) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// rtl/fifo_ptr_ctrl.sv - pointers, fill count, level flags and sticky errors
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int AF_LEVEL = 28,
  parameter int AE_LEVEL = 4,
  localparam int AW      = fifo_aw(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          wr_en,
  input  logic          rd_en,
  output logic          wr_ok,
  output logic          rd_ok,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic [AW-1:0] rd_ptr_next,
  output logic [AW:0]   count,
  output logic [AW:0]   count_next,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
  localparam logic [AW:0] AF_C    = AF_LEVEL[AW:0];
  localparam logic [AW:0] AE_C    = AE_LEVEL[AW:0];

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // Acceptance is judged on the registered flags only; a pop cannot make room for a same-edge push.
  assign wr_ok       = wr_en & ~full;
  assign rd_ok       = rd_en & ~empty;
  assign rd_ptr_next = rd_ok ? rd_ptr + 1'b1 : rd_ptr;

  always_comb begin
    count_next = count;
    case ({wr_ok, rd_ok})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_ptr_next;
      count  <= count_next;
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end

endmodule

// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - parametrised single-clock FIFO, standard or first-word-fall-through
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 32,
  parameter int AF_LEVEL = 28,
  parameter int AE_LEVEL = 4,
  parameter int FWFT     = FIFO_MODE_STD,
  localparam int AW      = fifo_aw(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [AW:0]       count,
  output logic              overflow,
  output logic              underflow
);

  if (DATA_W < 1) begin : g_bad_width
    $error("fifo_sync_param: DATA_W must be >= 1");
  end
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_sync_param: DEPTH must be a power of 2 and >= 4");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH - 1 || AE_LEVEL < 1 || AE_LEVEL > DEPTH - 1) begin : g_bad_level
    $error("fifo_sync_param: AF_LEVEL/AE_LEVEL must lie in 1..DEPTH-1");
  end
  if (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT) begin : g_bad_mode
    $error("fifo_sync_param: FWFT must be 0 or 1");
  end

  logic              wr_ok, rd_ok;
  logic [AW-1:0]     wr_ptr, rd_ptr, rd_ptr_next;
  logic [AW:0]       count_next;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] head_next;

  fifo_ptr_ctrl #(
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF_LEVEL),
    .AE_LEVEL (AE_LEVEL)
  ) u_ptr_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .wr_ok        (wr_ok),
    .rd_ok        (rd_ok),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .rd_ptr_next  (rd_ptr_next),
    .count        (count),
    .count_next   (count_next),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always_ff @(posedge clk) begin
    if (wr_ok && !clr) mem[wr_ptr] <= din;
  end

  // Head word after this edge; a word landing exactly at the new head bypasses the array.
  assign head_next = (wr_ok && (wr_ptr == rd_ptr_next)) ? din : mem[rd_ptr_next];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
    end else if (clr) begin
      dout <= '0;
    end else if (FWFT == FIFO_MODE_FWFT) begin
      if (count_next != '0) dout <= head_next;
    end else begin
      if (rd_ok) dout <= mem[rd_ptr];
    end
  end

endmodule
